wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order pipeline WB stage and the
//  long-latency multiply/divide unit (MDU). MDU results are queued in a small FIFO and written in
//  free WB slots; starved entries force a one-cycle pipeline stall. Sits between WB and regfile.
// PARAMETERS
//  DEPTH         4   MDU result FIFO entries; power of 2, >= 2
//  STARVE_LIMIT  8   cycles the FIFO head may wait before a forced drain; >= 1
//  CNTW  $clog2(DEPTH)+1   localparam, occupancy counter width
// PORTS
//  clk           in   1     clock
//  rst           in   1     asynchronous reset, active-high
//  wb_load       in   1     WB stage requests regfile write (ctrl load_regfile)
//  wb_rd         in   5     WB destination register
//  wb_data       in   32    WB write data (regfilemux output)
//  mdu_valid     in   1     MDU result valid
//  mdu_rd        in   5     MDU destination register
//  mdu_data      in   32    MDU result
//  mdu_ready     out  1     FIFO can accept a result this cycle
//  stall_pipe    out  1     freeze whole pipeline this cycle (registered)
//  rf_load       out  1     regfile write enable
//  rf_rd         out  5     regfile write address
//  rf_data       out  32    regfile write data
//  fifo_count    out  CNTW  current FIFO occupancy
// BEHAVIOUR
//  - Reset: FIFO empty, age=0, state NORMAL; stall_pipe=0, rf_load=0, rf_rd=0, rf_data=0,
//    fifo_count=0, mdu_ready=0 while rst high, 1 from first cycle after release.
//  - Pipe write is "real" only if wb_load && wb_rd!=0. rd=0 writes never reach rf_load.
//  - States: NORMAL, FORCE. stall_pipe = (state==FORCE).
//  - NORMAL grant (combinational): real pipe write -> rf_* = wb_*; else FIFO non-empty ->
//    rf_* = head, pop; else rf_load=0, rf_rd=0, rf_data=0.
//  - FORCE: WB inputs ignored (stage is frozen and re-presents next cycle); rf_* = head, pop.
//    FORCE lasts exactly one cycle, then NORMAL; age cleared.
//  - age: 0 when FIFO empty or on any pop; else +1 per cycle, saturating at STARVE_LIMIT.
//    NORMAL && age==STARVE_LIMIT && no pop this cycle -> next state FORCE.
//  - mdu_ready = (fifo_count != DEPTH), combinational. Push on mdu_valid && mdu_ready.
//    mdu_rd==0 results handshake normally but are dropped (no push, count unchanged).
//  - No bypass: a pushed entry is writable at the earliest the following cycle.
//  - Push and pop same cycle: count unchanged; when full, mdu_ready stays 0 even if popping.
//  - Pointers wrap modulo DEPTH; write order to regfile = FIFO order.
//  - WAW/RAW ordering vs pending MDU rd is enforced by the hazard unit, not here.
//  - Reset mid-operation discards all queued results and any pending FORCE.
// CONFIGURATION
//  WB_ARB_PERF_EN defined: adds outputs perf_conflicts[31:0] (cycles FIFO non-empty and pipe
//   won the port) and perf_forced[31:0] (FORCE cycles); saturating, reset 0.
//  Undefined: those ports and counters do not exist; behaviour otherwise identical.
// TESTING
//  - Reset: hold rst 3 cycles with mdu_valid=1 -> no push, rf_load=0, mdu_ready=0, count=0.
//  - Idle slot: mdu rd=5 data=0xDEADBEEF, wb_load=0 -> next cycle rf_load=1 rd=5, count 1->0.
//  - Conflict: wb_load=1 rd=3 every cycle, one MDU entry -> pipe writes for STARVE_LIMIT+1
//    cycles, then stall_pipe=1 one cycle with rf_rd=MDU rd, then pipe resumes.
//  - Full: DEPTH pushes with wb_load=1 rd=1 -> mdu_ready=0, count=DEPTH; extra push refused.
//  - x0: wb_load=1 wb_rd=0 with FIFO head rd=7 -> rf_rd=7 popped; mdu_rd=0 -> count unchanged.
//  - Wrap: push/pop 3*DEPTH entries, data=index -> rf_data sequence 0,1,2,... in order.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between the WB stage and queued MDU results; 0-cycle grant path.
// Optional WB_ARB_PERF_EN adds saturating conflict/forced-stall counters. MDU backpressure via mdu_ready.
module wb_port_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wb_load,
   input  logic [4:0]               wb_rd,
   input  logic [31:0]              wb_data,
   input  logic                     mdu_valid,
   input  logic [4:0]               mdu_rd,
   input  logic [31:0]              mdu_data,
   output logic                     mdu_ready,
   output logic                     stall_pipe,
   output logic                     rf_load,
   output logic [4:0]               rf_rd,
   output logic [31:0]              rf_data,
   output logic [$clog2(DEPTH):0]   fifo_count
`ifdef WB_ARB_PERF_EN
  ,output logic [31:0]              perf_conflicts,
   output logic [31:0]              perf_forced
`endif
);

   localparam int CNTW = $clog2(DEPTH) + 1;
   localparam int PW   = $clog2(DEPTH);
   localparam int AW   = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {NORMAL, FORCE} state_t;

   state_t          state_q, state_d;
   logic [CNTW-1:0] count_q, count_d;
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW-1:0]   age_q, age_d;
   logic [4:0]      rd_mem_q   [DEPTH];
   logic [31:0]     data_mem_q [DEPTH];

   logic empty, pipe_real, push, pop, conflict;

   assign empty      = (count_q == '0);
   assign pipe_real  = wb_load && (wb_rd != 5'd0);
   assign mdu_ready  = !rst && (count_q != CNTW'(DEPTH));
   assign push       = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
   assign stall_pipe = (state_q == FORCE);
   assign fifo_count = count_q;

   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      conflict = 1'b0;
      rf_load  = 1'b0;
      rf_rd    = 5'd0;
      rf_data  = 32'd0;
      case (state_q)
         NORMAL: begin
            if (pipe_real) begin
               rf_load  = 1'b1;
               rf_rd    = wb_rd;
               rf_data  = wb_data;
               conflict = !empty;
            end else if (!empty) begin
               rf_load = 1'b1;
               rf_rd   = rd_mem_q[rd_ptr_q];
               rf_data = data_mem_q[rd_ptr_q];
               pop     = 1'b1;
            end
            if ((age_q == AW'(STARVE_LIMIT)) && !pop) state_d = FORCE;
         end
         FORCE: begin
            // The frozen WB stage re-presents its write next cycle, so its inputs are ignored here.
            if (!empty) begin
               rf_load = 1'b1;
               rf_rd   = rd_mem_q[rd_ptr_q];
               rf_data = data_mem_q[rd_ptr_q];
               pop     = 1'b1;
            end
            state_d = NORMAL;
         end
         default: state_d = NORMAL;
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
      age_d = age_q;
      if (empty || pop)                     age_d = '0;
      else if (age_q != AW'(STARVE_LIMIT))  age_d = age_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= NORMAL;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         age_q    <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         age_q   <= age_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem_q[wr_ptr_q]   <= mdu_rd;
         data_mem_q[wr_ptr_q] <= mdu_data;
      end
   end

`ifdef WB_ARB_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_conflicts <= '0;
         perf_forced    <= '0;
      end else begin
         if (conflict && (perf_conflicts != '1)) perf_conflicts <= perf_conflicts + 1'b1;
         if (stall_pipe && (perf_forced != '1))  perf_forced    <= perf_forced + 1'b1;
      end
   end
`else
   logic unused_conflict;
   assign unused_conflict = conflict;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, idle-slot drain, starvation FORCE, full FIFO,
// x0 handling, pointer wrap and mid-operation reset.
module tb_wb_port_arbiter;

   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   logic        clk, rst;
   logic        wb_load, mdu_valid;
   logic [4:0]  wb_rd, mdu_rd;
   logic [31:0] wb_data, mdu_data;
   logic        mdu_ready, stall_pipe, rf_load;
   logic [4:0]  rf_rd;
   logic [31:0] rf_data;
   logic [2:0]  fifo_count;

   int checks = 0;
   int errors = 0;

   wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .wb_load(wb_load), .wb_rd(wb_rd), .wb_data(wb_data),
      .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
      .mdu_ready(mdu_ready), .stall_pipe(stall_pipe),
      .rf_load(rf_load), .rf_rd(rf_rd), .rf_data(rf_data),
      .fifo_count(fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change at posedge+1; outputs are sampled at posedge+2.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; wb_load = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
      mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h1;
      #1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("rst_rf_load", {31'd0, rf_load}, 32'd0);
         check("rst_ready", {31'd0, mdu_ready}, 32'd0);
         check("rst_count", {29'd0, fifo_count}, 32'd0);
         check("rst_stall", {31'd0, stall_pipe}, 32'd0);
         check("rst_rf_rd", {27'd0, rf_rd}, 32'd0);
         check("rst_rf_data", rf_data, 32'd0);
         tick();
      end
      rst = 1'b0; mdu_valid = 1'b0;
      #1;
      check("post_rst_ready", {31'd0, mdu_ready}, 32'd1);
      check("post_rst_count", {29'd0, fifo_count}, 32'd0);
      tick();

      // Idle slot drain: no bypass, written the cycle after the push.
      mdu_valid = 1'b1; mdu_rd = 5'd5; mdu_data = 32'hDEADBEEF;
      #1;
      check("idle_no_bypass", {31'd0, rf_load}, 32'd0);
      tick();
      mdu_valid = 1'b0;
      #1;
      check("idle_count1", {29'd0, fifo_count}, 32'd1);
      check("idle_rf_load", {31'd0, rf_load}, 32'd1);
      check("idle_rf_rd", {27'd0, rf_rd}, 32'd5);
      check("idle_rf_data", rf_data, 32'hDEADBEEF);
      tick();
      #1;
      check("idle_count0", {29'd0, fifo_count}, 32'd0);
      check("idle_rf_idle", {31'd0, rf_load}, 32'd0);
      tick();

      // Starvation: pipe owns the port LIMIT+1 cycles, then one FORCE cycle.
      wb_load = 1'b1; wb_rd = 5'd3; wb_data = 32'h1111;
      mdu_valid = 1'b1; mdu_rd = 5'd12; mdu_data = 32'hC0FFEE;
      tick();
      mdu_valid = 1'b0;
      for (int i = 0; i < LIMIT + 1; i++) begin
         #1;
         check("conf_pipe_rd", {27'd0, rf_rd}, 32'd3);
         check("conf_no_stall", {31'd0, stall_pipe}, 32'd0);
         check("conf_count", {29'd0, fifo_count}, 32'd1);
         tick();
      end
      #1;
      check("force_stall", {31'd0, stall_pipe}, 32'd1);
      check("force_rf_load", {31'd0, rf_load}, 32'd1);
      check("force_rf_rd", {27'd0, rf_rd}, 32'd12);
      check("force_rf_data", rf_data, 32'hC0FFEE);
      tick();
      #1;
      check("resume_stall", {31'd0, stall_pipe}, 32'd0);
      check("resume_rf_rd", {27'd0, rf_rd}, 32'd3);
      check("resume_count", {29'd0, fifo_count}, 32'd0);
      tick();

      // Fill under continuous pipe writes.
      wb_rd = 5'd1; mdu_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         mdu_rd = 5'(20 + i); mdu_data = 32'(100 + i);
         #1;
         check("fill_ready", {31'd0, mdu_ready}, 32'd1);
         tick();
      end
      mdu_rd = 5'd30; mdu_data = 32'hBAD;
      #1;
      check("full_ready", {31'd0, mdu_ready}, 32'd0);
      check("full_count", {29'd0, fifo_count}, 32'd4);
      tick();
      #1;
      check("full_refused", {29'd0, fifo_count}, 32'd4);
      wb_load = 1'b0;
      #1;
      check("full_pop_ready", {31'd0, mdu_ready}, 32'd0);
      check("drain_rd0", {27'd0, rf_rd}, 32'd20);
      check("drain_data0", rf_data, 32'd100);
      tick();
      mdu_valid = 1'b0;
      for (int i = 1; i < DEPTH; i++) begin
         #1;
         check("drain_rd", {27'd0, rf_rd}, 32'(20 + i));
         check("drain_data", rf_data, 32'(100 + i));
         tick();
      end
      #1;
      check("drain_count", {29'd0, fifo_count}, 32'd0);

      // x0: rd=0 pipe write yields to the FIFO head; rd=0 MDU result is dropped.
      mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h77;
      tick();
      wb_load = 1'b1; wb_rd = 5'd0; wb_data = 32'h5555;
      mdu_rd = 5'd0; mdu_data = 32'h99;
      #1;
      check("x0_count1", {29'd0, fifo_count}, 32'd1);
      check("x0_rf_load", {31'd0, rf_load}, 32'd1);
      check("x0_rf_rd", {27'd0, rf_rd}, 32'd7);
      check("x0_rf_data", rf_data, 32'h77);
      check("x0_ready", {31'd0, mdu_ready}, 32'd1);
      tick();
      mdu_valid = 1'b0;
      #1;
      check("x0_dropped", {29'd0, fifo_count}, 32'd0);
      check("x0_idle", {31'd0, rf_load}, 32'd0);
      wb_load = 1'b0;

      // Pointer wrap: 3*DEPTH entries stream through in order.
      for (int k = 0; k <= 3 * DEPTH; k++) begin
         mdu_valid = (k < 3 * DEPTH);
         mdu_rd = 5'((k % 8) + 1);
         mdu_data = 32'(k);
         #1;
         if (k == 0) check("wrap_first_idle", {31'd0, rf_load}, 32'd0);
         else        check("wrap_data", rf_data, 32'(k - 1));
         tick();
      end
      mdu_valid = 1'b0;
      #1;
      check("wrap_count", {29'd0, fifo_count}, 32'd0);

      // Mid-operation reset discards queued results.
      wb_load = 1'b1; wb_rd = 5'd2; mdu_valid = 1'b1; mdu_rd = 5'd4;
      tick();
      tick();
      mdu_valid = 1'b0;
      #1;
      check("mid_count2", {29'd0, fifo_count}, 32'd2);
      rst = 1'b1;
      #1;
      check("mid_rst_count", {29'd0, fifo_count}, 32'd0);
      tick();
      rst = 1'b0; wb_load = 1'b0;
      #1;
      check("mid_rst_idle", {31'd0, rf_load}, 32'd0);
      check("mid_rst_stall", {31'd0, stall_pipe}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
